generic_divider: RTL and testbench

GENERIC_DIVIDER -- requirements
Module: generic_divider

---
 rtl/generic_pkg.sv | 20 ++
 rtl/generic_divider_if.sv | 30 +++
 rtl/generic_subtractor.sv | 23 ++
 rtl/generic_divider.sv | 136 +++++++++++++
 tb/tb_generic_divider.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/generic_pkg.sv
// Shared definitions for the generic_divider slice.
//   div_state_t : divider control states (IDLE / RUN / DONE)
//   DEFAULT_N   : default operand/result width
//   cnt_width() : iteration counter width for an n-bit divider
package generic_pkg;

  localparam int DEFAULT_N = 20;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } div_state_t;

  // One spare bit so the counter can step past n-1 without wrapping.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/generic_divider_if.sv
// Request/result bundle of the divider.
//   start, dividend, divisor                          : requester -> divider
//   quotient, remainder, busy, done, div_by_zero      : divider -> requester
// master = requester side, slave = divider side.
interface generic_divider_if
  import generic_pkg::*;
#(
  parameter int N = DEFAULT_N
);

  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );

endinterface

// File: rtl/generic_subtractor.sv
// Combinational W-bit subtractor: diff = a - b - borrow_in.
//   a, b       : W-bit unsigned operands
//   borrow_in  : incoming borrow
//   diff       : W-bit difference
//   borrow_out : 1 when the result went below zero
module generic_subtractor #(
  parameter int W = 21
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         borrow_in,
  output logic [W-1:0] diff,
  output logic         borrow_out
);

  logic [W:0] ext;

  // Extra top bit captures the borrow out of the W-bit subtraction.
  assign ext        = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, borrow_in};
  assign diff       = ext[W-1:0];
  assign borrow_out = ext[W];

endmodule

// File: rtl/generic_divider.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
//   clk, rst : clock and synchronous active-high reset
//   bus      : generic_divider_if.slave
//              start/dividend/divisor in; quotient/remainder/div_by_zero
//              registered results; busy during RUN; done one-cycle pulse.
// A zero divisor bypasses RUN and completes on the next edge with
// quotient = all ones, remainder = dividend, div_by_zero = 1.
module generic_divider
  import generic_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic             clk,
  input  logic             rst,
  generic_divider_if.slave bus
);

  localparam int            CW        = cnt_width(N);
  localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

  div_state_t    state;
  div_state_t    state_nxt;
  logic [CW-1:0] iter_cnt;

  // Working registers: partial remainder (N+1 bits), quotient shift
  // register (starts holding the dividend), latched divisor.
  logic [N:0]    rem_r;
  logic [N-1:0]  quo_r;
  logic [N-1:0]  dvs_r;

  logic [N:0]    rem_shift;
  logic [N:0]    trial;
  logic          borrow;
  logic [N:0]    rem_nxt;
  logic [N-1:0]  quo_nxt;

  logic          accept;
  logic          div_zero;
  logic          last_iter;
  logic          busy_c;
  logic          done_c;

  logic [N-1:0]  quotient_r;
  logic [N-1:0]  remainder_r;
  logic          dbz_r;

  // Shift {remainder, quotient} left by one; the dividend MSB still held
  // in quo_r enters the remainder LSB.
  assign rem_shift = (rem_r << 1) | (N + 1)'(quo_r[N-1]);

  generic_subtractor #(
    .W (N + 1)
  ) u_sub (
    .a          (rem_shift),
    .b          ({1'b0, dvs_r}),
    .borrow_in  (1'b0),
    .diff       (trial),
    .borrow_out (borrow)
  );

  // Restore on borrow; otherwise keep the trial and record a 1.
  assign rem_nxt   = borrow ? rem_shift : trial;
  assign quo_nxt   = {quo_r[N-2:0], ~borrow};

  assign accept    = bus.start && (state != S_RUN);
  assign div_zero  = (bus.divisor == '0);
  assign last_iter = (iter_cnt == LAST_ITER);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_c    = 1'b0;
    done_c    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (accept) state_nxt = div_zero ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy_c = 1'b1;
        if (last_iter) state_nxt = S_DONE;
      end
      S_DONE: begin
        done_c = 1'b1;
        if (accept) state_nxt = div_zero ? S_DONE : S_RUN;
        else        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                 iter_cnt <= '0;
    else if (accept)         iter_cnt <= '0;
    else if (state == S_RUN) iter_cnt <= iter_cnt + CW'(1);
  end

  // Working datapath carries no reset; it is always reloaded on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_r <= '0;
      quo_r <= bus.dividend;
      dvs_r <= bus.divisor;
    end else if (state == S_RUN) begin
      rem_r <= rem_nxt;
      quo_r <= quo_nxt;
    end
  end

  // Result registers change only when a division completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      quotient_r  <= '0;
      remainder_r <= '0;
      dbz_r       <= 1'b0;
    end else if (accept && div_zero) begin
      quotient_r  <= '1;
      remainder_r <= bus.dividend;
      dbz_r       <= 1'b1;
    end else if ((state == S_RUN) && last_iter) begin
      quotient_r  <= quo_nxt;
      remainder_r <= N'(rem_nxt);
      dbz_r       <= 1'b0;
    end
  end

  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.busy        = busy_c;
  assign bus.done        = done_c;

endmodule

// File: tb/tb_generic_divider.sv
module tb_generic_divider;
  localparam int N = 20;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  generic_divider_if #(.N(N)) bus ();

  generic_divider #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives start for one cycle (from a negedge), then counts rising edges
  // until done is seen at a negedge. lat = 1 means done right after the
  // accepting edge. At cycle inj (if > 0) a 50/5 start is injected.
  // Returns at the negedge where done is high (or on timeout).
  task automatic run_div(input logic [N-1:0] dvd, input logic [N-1:0] dvs,
                         input int inj, output int lat);
    int cnt;
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dvs;
    @(posedge clk);
    cnt = 1;
    @(negedge clk);
    bus.start = 1'b0;
    while (!bus.done && cnt < 100) begin
      if (inj > 0 && cnt == inj) begin
        check("busy_when_injected", bus.busy, 1'b1);
        bus.start    = 1'b1;
        bus.dividend = 20'd50;
        bus.divisor  = 20'd5;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      cnt++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    lat = cnt;
  endtask

  task automatic check_result(input string tag, input logic [N-1:0] q,
                              input logic [N-1:0] r, input logic z);
    check({tag, "_q"}, bus.quotient, q);
    check({tag, "_r"}, bus.remainder, r);
    check({tag, "_dbz"}, bus.div_by_zero, z);
  endtask

  initial begin
    int lat;
    int done_seen;
    n_tests = 0;
    n_fail  = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dbz", bus.div_by_zero, 0);

    // Normal 100 / 7 = 14 r 2
    run_div(20'd100, 20'd7, 0, lat);
    check("norm_latency", lat, 21);
    check_result("norm", 20'd14, 20'd2, 1'b0);
    @(negedge clk);
    check("norm_done_pulse", bus.done, 0);
    check("norm_idle_busy", bus.busy, 0);
    check("norm_hold_q", bus.quotient, 20'd14);

    // Maximum quotient
    run_div(20'hFFFFF, 20'd1, 0, lat);
    check("maxq_latency", lat, 21);
    check_result("maxq", 20'hFFFFF, 20'd0, 1'b0);
    @(negedge clk);

    // Dividend below divisor
    run_div(20'd5, 20'd9, 0, lat);
    check_result("small", 20'd0, 20'd5, 1'b0);
    @(negedge clk);

    // Divide by zero
    run_div(20'd1234, 20'd0, 0, lat);
    check("dbz_latency", lat, 1);
    check_result("dbz", 20'hFFFFF, 20'd1234, 1'b1);
    @(negedge clk);

    // Large divisor: 0xFFFFF / 0x12345 = 14 r 4665 (also clears dbz)
    run_div(20'hFFFFF, 20'h12345, 0, lat);
    check_result("bigdvs", 20'd14, 20'd4665, 1'b0);
    @(negedge clk);

    // Divisor at maximum: 0xABCDE / 0xFFFFF = 0 r 0xABCDE
    run_div(20'hABCDE, 20'hFFFFF, 0, lat);
    check_result("maxdvs", 20'd0, 20'hABCDE, 1'b0);
    @(negedge clk);

    // start while busy is ignored
    run_div(20'd100, 20'd7, 5, lat);
    check("busy_latency", lat, 21);
    check_result("busy", 20'd14, 20'd2, 1'b0);
    repeat (5) @(negedge clk);
    check("busy_hold_q", bus.quotient, 20'd14);
    check("busy_hold_r", bus.remainder, 20'd2);
    check("busy_hold_done", bus.done, 0);

    // Reset at cycle 10 of a division
    bus.start    = 1'b1;
    bus.dividend = 20'd100;
    bus.divisor  = 20'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_q", bus.quotient, 0);
    check("mid_rst_r", bus.remainder, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_done", bus.done, 0);
    check("mid_rst_dbz", bus.div_by_zero, 0);
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) done_seen = 1;
    end
    check("mid_rst_no_done", done_seen, 0);

    // Back-to-back: second start issued in the DONE cycle of the first
    run_div(20'd100, 20'd7, 0, lat);
    check_result("b2b_first", 20'd14, 20'd2, 1'b0);
    run_div(20'd1000, 20'd33, 0, lat);
    check("b2b_latency", lat, 21);
    check_result("b2b_second", 20'd30, 20'd10, 1'b0);
    @(negedge clk);
    check("b2b_idle_done", bus.done, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
